// File: rtl/i2c_reg_target_if.sv
// Local side of i2c_reg_target: register read port, write-notify strobe and bus-busy flag.
interface i2c_reg_target_if;
    logic [7:0] loc_addr;
    logic [7:0] loc_data;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport master (output loc_addr, input loc_data, wr_strobe, wr_addr, wr_data, busy);
    modport slave  (input loc_addr, output loc_data, wr_strobe, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target with an 8-bit-addressed register file (ADV7513 register-map stand-in).
// Define I2C_TGT_AUTOINC_EN to make the register pointer auto-increment per data byte.
module i2c_reg_target #(
    parameter logic [6:0] CHIP_ADDR = 7'h39,
    parameter int         REG_DEPTH = 256,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    inout  wire             sda,
    input  logic            scl,
    i2c_reg_target_if.slave loc
);

`ifdef I2C_TGT_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw;
    logic       mack;
    logic       sda_oe;
    logic [7:0] regs [REG_DEPTH];

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;

    function automatic logic [IDX_W-1:0] idx(input logic [7:0] a);
        logic [8:0] m;
        m = {1'b0, a} % 9'(REG_DEPTH);
        return m[IDX_W-1:0];
    endfunction

    // Reset gates the driver directly so an aborted read frees the bus in the same cycle.
    assign sda = (sda_oe && !reset) ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign rx_byte   = {shreg[6:0], sda_s};
    assign rd_byte   = regs[idx(ptr)];

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync      <= 2'b11;
            sda_sync      <= 2'b11;
            scl_q         <= 1'b1;
            sda_q         <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= 8'h00;
            ptr           <= 8'h00;
            rw            <= 1'b0;
            mack          <= 1'b0;
            sda_oe        <= 1'b0;
            loc.busy      <= 1'b0;
            loc.wr_strobe <= 1'b0;
            loc.wr_addr   <= 8'h00;
            loc.wr_data   <= 8'h00;
            loc.loc_data  <= 8'h00;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= RESET_VAL;
        end else begin
            scl_sync      <= {scl_sync[0], scl};
            sda_sync      <= {sda_sync[0], sda};
            scl_q         <= scl_s;
            sda_q         <= sda_s;
            loc.wr_strobe <= 1'b0;
            // Read-before-write ordering: a same-cycle I2C write shows up on the next read.
            loc.loc_data  <= regs[idx(loc.loc_addr)];

            if (start_det) begin
                state    <= DEV;
                bit_cnt  <= 3'd0;
                sda_oe   <= 1'b0;
                mack     <= 1'b0;
                loc.busy <= 1'b1;
            end else if (stop_det) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                mack     <= 1'b0;
                loc.busy <= 1'b0;
            end else begin
                unique case (state)
                    DEV: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == CHIP_ADDR) begin
                                rw    <= rx_byte[0];
                                state <= DEV_ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    // First falling edge asserts the ACK, the second one ends it.
                    DEV_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            shreg   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 3'd0;
                            state   <= RDAT;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= REG;
                        end
                    end
                    REG: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr   <= rx_byte;
                            state <= REG_ACK;
                        end
                    end
                    REG_ACK, WDAT_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= WDAT;
                        end
                    end
                    WDAT: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            regs[idx(ptr)] <= rx_byte;
                            loc.wr_strobe  <= 1'b1;
                            loc.wr_addr    <= ptr;
                            loc.wr_data    <= rx_byte;
                            if (AUTOINC) ptr <= ptr + 8'd1;
                            state <= WDAT_ACK;
                        end
                    end
                    RDAT: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= RDAT_ACK;
                        end else if (scl_fall) begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    // mack marks that the master acked; the next fall loads the following byte.
                    RDAT_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= IDLE;
                            end else begin
                                mack <= 1'b1;
                                if (AUTOINC) ptr <= ptr + 8'd1;
                            end
                        end else if (scl_fall) begin
                            if (mack) begin
                                mack    <= 1'b0;
                                shreg   <= rd_byte;
                                sda_oe  <= ~rd_byte[7];
                                bit_cnt <= 3'd0;
                                state   <= RDAT;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Randomized bench for i2c_reg_target: bit-banged I2C master plus array/queue reference model.
module tb_i2c_reg_target;
    localparam int Q = 8;
`ifdef I2C_TGT_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        scl   = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  mregs [256];
    logic [7:0]  wbuf [4];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);
    always #5 clk = ~clk;

    i2c_reg_target_if ifc ();
    i2c_reg_target dut (.clk(clk), .reset(reset), .sda(sda), .scl(scl), .loc(ifc));

    always @(negedge clk) if (ifc.wr_strobe) obs_q.push_back({ifc.wr_addr, ifc.wr_data});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic qwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        m_low = !b;
        qwait(Q); scl = 1'b1;
        qwait(2*Q); scl = 1'b0;
        qwait(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0;
        qwait(Q); scl = 1'b1;
        qwait(Q); b = sda;
        qwait(Q); scl = 1'b0;
        qwait(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(s);
        ack = !s;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(s);
            d[i] = s;
        end
        send_bit(nack);
        m_low = 1'b0;
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        qwait(Q); scl = 1'b1;
        qwait(Q); m_low = 1'b1;
        qwait(Q); scl = 1'b0;
        qwait(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        qwait(Q); scl = 1'b1;
        qwait(Q); m_low = 1'b0;
        qwait(Q);
    endtask

    task automatic chk_strobes(input string tag);
        chk({tag, "_nstrobe"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_strobe"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic loc_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk) ifc.loc_addr = a;
        @(negedge clk) d = ifc.loc_data;
    endtask

    task automatic do_write(input logic [7:0] r, input int n);
        logic       a;
        logic [7:0] ad;
        i2c_start();
        chk("w_busy_on", 32'(ifc.busy), 1);
        send_byte(8'h72, a); chk("w_dev_ack", 32'(a), 1);
        send_byte(r, a);     chk("w_reg_ack", 32'(a), 1);
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], a); chk("wdat_ack", 32'(a), 1);
            ad = AUTOINC ? r + 8'(k) : r;
            mregs[ad] = wbuf[k];
            exp_q.push_back({ad, wbuf[k]});
        end
        i2c_stop();
        chk("w_busy_off", 32'(ifc.busy), 0);
        chk_strobes("wr");
    endtask

    task automatic do_read(input logic [7:0] r, input int n);
        logic       a;
        logic [7:0] d, ad;
        i2c_start();
        send_byte(8'h72, a); chk("r_dev_ack", 32'(a), 1);
        send_byte(r, a);     chk("r_reg_ack", 32'(a), 1);
        i2c_start();
        send_byte(8'h73, a); chk("r_devrd_ack", 32'(a), 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(d, k == n - 1);
            ad = AUTOINC ? r + 8'(k) : r;
            chk("rdat", 32'(d), 32'(mregs[ad]));
        end
        i2c_stop();
        chk("r_busy_off", 32'(ifc.busy), 0);
        chk("r_sda_rel", 32'(sda), 1);
        chk_strobes("rd");
    endtask

    initial begin
        logic       a, b;
        logic [7:0] d, r;
        int         n;
        ifc.loc_addr = 8'h00;
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;

        qwait(5);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_strobe", 32'(ifc.wr_strobe), 0);
        chk("rst_wr_addr", 32'(ifc.wr_addr), 0);
        chk("rst_wr_data", 32'(ifc.wr_data), 0);
        chk("rst_loc_data", 32'(ifc.loc_data), 0);
        chk("rst_sda", 32'(sda), 1);
        reset = 1'b0;
        qwait(5);

        // Write 0xA5 to 0x15, read it back across a repeated START.
        wbuf[0] = 8'hA5;
        do_write(8'h15, 1);
        do_read(8'h15, 1);

        // Wrong device address: no ACK anywhere, no writes.
        i2c_start();
        send_byte(8'h74, a); chk("mis_dev_ack", 32'(a), 0);
        send_byte(8'h10, a); chk("mis_reg_ack", 32'(a), 0);
        send_byte(8'h99, a); chk("mis_dat_ack", 32'(a), 0);
        i2c_stop();
        chk_strobes("mis");
        loc_read(8'h10, d); chk("mis_reg10", 32'(d), 32'(mregs[8'h10]));

        // Burst across the 0xFF -> 0x00 boundary.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(8'hFE, 3);
        loc_read(8'hFE, d); chk("burst_fe", 32'(d), 32'(mregs[8'hFE]));
        loc_read(8'hFF, d); chk("burst_ff", 32'(d), 32'(mregs[8'hFF]));
        loc_read(8'h00, d); chk("burst_00", 32'(d), 32'(mregs[8'h00]));
        do_read(8'hFE, 3);

        // STOP after four data bits must not write.
        i2c_start();
        send_byte(8'h72, a); chk("abort_dev_ack", 32'(a), 1);
        send_byte(8'h30, a); chk("abort_reg_ack", 32'(a), 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        chk("abort_busy", 32'(ifc.busy), 0);
        chk_strobes("abort");
        loc_read(8'h30, d); chk("abort_reg30", 32'(d), 32'(mregs[8'h30]));

        // Local read port sees an I2C write.
        wbuf[0] = 8'h5A;
        do_write(8'h40, 1);
        loc_read(8'h40, d); chk("loc_40", 32'(d), 32'h5A);

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 3);
            r = 8'($urandom);
            for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
            do_write(r, n);
            do_read(r, n);
            r = 8'($urandom);
            loc_read(r, d); chk("rand_loc", 32'(d), 32'(mregs[r]));
        end

        // Reset while the target drives a 0 bit of a read byte.
        wbuf[0] = 8'h00;
        do_write(8'h60, 1);
        i2c_start();
        send_byte(8'h72, a);
        send_byte(8'h60, a);
        i2c_start();
        send_byte(8'h73, a); chk("rr_dev_ack", 32'(a), 1);
        for (int i = 0; i < 4; i++) recv_bit(b);
        chk("rr_bit3_drive", 32'(sda), 0);
        reset = 1'b1;
        #1;
        chk("rr_sda_release", 32'(sda), 1);
        scl = 1'b1;
        qwait(4);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        qwait(4);
        chk("rr_busy", 32'(ifc.busy), 0);
        chk_strobes("rr");
        loc_read(8'h15, d); chk("rr_loc15", 32'(d), 0);
        loc_read(8'h40, d); chk("rr_loc40", 32'(d), 0);
        r = 8'($urandom);
        loc_read(r, d); chk("rr_loc_rand", 32'(d), 0);

        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        do_write(8'h7F, 2);
        do_read(8'h7F, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C target (responder) holding an 8-bit-addressed register file; the other end of the I2C master read/write path used for ADV7513 register access.
- Serves as an ADV7513 register-map stand-in for board-level loopback and simulation of the register read/write blocks.
- Also exposes a local write-notify strobe and a local read port, so surrounding logic can observe and preload registers.

Parameters:
- CHIP_ADDR, 7'h39, 7-bit target address (8-bit write form 0x72).
- REG_DEPTH, 256, number of 8-bit registers. Valid values: 1..256. The address LSBs index the array, modulo REG_DEPTH.
- RESET_VAL, 8'h00, value loaded into every register on reset.

Ports:
- clk  in  1  system clock; at least 16x SCL rate.
- reset  in  1  synchronous, active-high.
- sda  inout  1  I2C data; open-drain; driven only low or 'z'.
- scl  in  1  I2C clock; no clock stretching.
- loc_addr  in  8  local read address.
- loc_data  out  8  register[loc_addr]; 1-cycle latency.
- wr_strobe  out  1  1-cycle pulse per I2C data byte written.
- wr_addr  out  8  register address of that write.
- wr_data  out  8  byte written.
- busy  out  1  high from START until STOP.

Behaviour:
- Input conditioning: sda and scl each pass through a 2-flop synchronizer, then a 1-flop history for edge detection.
- Bus events:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Data is sampled on the synchronized scl rising edge.
  - sda drive changes only on the cycle after a synchronized scl falling edge.
- Reset:
  - State goes to IDLE; sda is released ('z').
  - busy=0, wr_strobe=0, wr_addr=0, wr_data=0, loc_data=0.
  - All registers load RESET_VAL; the register pointer is cleared to 0.
  - Reset asserted mid-transaction aborts immediately and releases sda in the same cycle.
- State machine: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
- IDLE: START goes to DEV with bit counter=0.
- DEV: shift 8 bits, MSB first.
  - Address match: go to DEV_ACK.
  - Mismatch: go to IDLE and ignore the bus until the next START.
- DEV_ACK: drive sda low for the 9th SCL period.
  - R/W=0: go to REG.
  - R/W=1: go to RDAT.
- REG: shift 8 bits into the pointer, then REG_ACK (drive low), then WDAT.
- WDAT: shift 8 bits.
  - On the 8th scl rise: write register[pointer], and pulse wr_strobe for 1 cycle with wr_addr=pointer and wr_data=byte.
  - Then WDAT_ACK (drive low), then WDAT.
- RDAT: shift out register[pointer] MSB first.
  - Bit 7 is presented after the falling edge that ends the preceding ACK.
  - Drive low for 0 bits; release for 1 bits.
  - After 8 bits go to RDAT_ACK and release sda.
- RDAT_ACK: sample the master's bit on scl rise.
  - ACK(0): go to RDAT with the next byte.
  - NACK(1): go to IDLE and wait for STOP.
- STOP in any state: go to IDLE, release sda, busy=0.
- Repeated START in any state: go to DEV. The pointer is retained, so a write-pointer-then-restart-read sequence returns register[pointer].
- Pointer arithmetic: 8-bit with natural wrap 0xFF→0x00; the array index is pointer mod REG_DEPTH.
- Simultaneous local read and I2C write to the same address: loc_data returns the old value that cycle and the new value on the following read.
- wr_strobe never asserts during reads, address mismatch, or after reset.

Optional Feature:
- Macro I2C_TGT_AUTOINC_EN.
- Defined: the pointer increments by 1 after each data byte is written (at the 8th-bit write) and after each byte is read (at the RDAT_ACK sample). Sequential bursts therefore walk registers, wrapping at 0xFF→0x00.
- Undefined: the pointer is fixed for the whole transaction.
  - Multi-byte writes overwrite the same register, with wr_strobe per byte.
  - Multi-byte reads return the same register repeatedly.

Test Plan:
- Write then read: START, 0x72, 0x15, 0xA5, STOP → three ACKs, one wr_strobe with wr_addr=0x15 and wr_data=0xA5. Then START, 0x72, 0x15, repeated START, 0x73 → target returns 0xA5; master NACK then STOP → busy=0, sda released.
- Address mismatch: START, 0x74, ... → no ACK (sda stays 'z' in the 9th period), no wr_strobe, state IDLE until the next START.
- Burst with I2C_TGT_AUTOINC_EN: write 0xFE, data 0x11, 0x22, 0x33 → registers 0xFE=0x11, 0xFF=0x22, 0x00=0x33. Without the macro → register 0xFE=0x33 and three wr_strobes.
- Reset mid-read: assert reset while bit 3 of an RDAT byte of 0x00 is driving sda low → sda='z' in the same cycle, loc_data for any address reads 0x00 afterwards, busy=0.
- Mid-write abort: STOP after 4 bits of WDAT → no register change, no wr_strobe, IDLE.
- Local port: after an I2C write of 0x5A to 0x40, loc_addr=0x40 → loc_data=0x5A one cycle later.
